// File: rtl/gfx_pkg.sv
// Shared FSM state encoding and default geometry for the graphics memory bank responder.
package gfx_pkg;
  localparam int BITS_DEFAULT              = 16;
  localparam int BANK_ADDRESS_BITS_DEFAULT = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } gfx_state_e;
endpackage

// File: rtl/bank_ram.sv
// Single-port synchronous RAM with a registered read port; a write leaves the read register untouched.
module bank_ram
  import gfx_pkg::*;
#(
  parameter int BITS      = BITS_DEFAULT,
  parameter int ADDR_BITS = BANK_ADDRESS_BITS_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [BITS-1:0]      din,
  output logic [BITS-1:0]      dout
);
  logic [BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end
endmodule

// File: rtl/memory_bank_responder.sv
// Memory bank shared between a CPU port (always wins) and a graphics read requester.
// Optional one-entry graphics prefetch buffer enabled by macro GFX_BANK_PREFETCH_EN.
module memory_bank_responder
  import gfx_pkg::*;
#(
  parameter int BITS              = BITS_DEFAULT,
  parameter int BANK_ADDRESS_BITS = BANK_ADDRESS_BITS_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [BANK_ADDRESS_BITS-1:0] CPU_ADDR,
  input  logic [BITS-1:0]              CPU_DIN,
  input  logic                         CPU_WR,
  input  logic                         CPU_RD,
  output logic [BITS-1:0]              CPU_DOUT,
  input  logic [BANK_ADDRESS_BITS-1:0] GFX_ADDR,
  input  logic                         GFX_VALID,
  output logic [BITS-1:0]              GFX_DOUT,
  output logic                         GFX_READY
);
  gfx_state_e                   state;
  logic                         cpu_acc_p0;
  logic                         gfx_req_p0;
  logic                         ram_en;
  logic                         ram_we;
  logic [BANK_ADDRESS_BITS-1:0] ram_addr;
  logic [BITS-1:0]              ram_din;
  logic [BITS-1:0]              ram_dout;
  logic                         cpu_rd_p1;
  logic [BITS-1:0]              cpu_dout_q;

  assign cpu_acc_p0 = CPU_WR | CPU_RD;

`ifdef GFX_BANK_PREFETCH_EN
  localparam logic [BANK_ADDRESS_BITS-1:0] ADDR_ONE = 1;

  logic                         pf_issue_p0;
  logic                         pf_wr_hit_p0;
  logic                         pf_hit_p0;
  logic                         pf_pend_p1;
  logic                         pf_vld;
  logic [BANK_ADDRESS_BITS-1:0] pf_tag;
  logic [BANK_ADDRESS_BITS-1:0] served_addr;
  logic [BITS-1:0]              pf_data;

  assign pf_issue_p0  = (state == ST_RESP) && !cpu_acc_p0;
  assign pf_wr_hit_p0 = CPU_WR && (CPU_ADDR == pf_tag);
  // While the prefetch read is still in the RAM output register, a match can be served from it directly.
  assign pf_hit_p0    = (state == ST_IDLE) && GFX_VALID && (pf_vld || pf_pend_p1)
                        && (pf_tag == GFX_ADDR) && !pf_wr_hit_p0;
  assign gfx_req_p0   = (state == ST_IDLE) && GFX_VALID && !cpu_acc_p0 && !pf_hit_p0;
`else
  assign gfx_req_p0   = (state == ST_IDLE) && GFX_VALID && !cpu_acc_p0;
`endif

  // Port arbitration: CPU first, then a new graphics read, then the prefetch read.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = GFX_ADDR;
    ram_din  = CPU_DIN;
    if (cpu_acc_p0) begin
      ram_en   = 1'b1;
      ram_we   = CPU_WR;
      ram_addr = CPU_ADDR;
    end else if (gfx_req_p0) begin
      ram_en   = 1'b1;
    end
`ifdef GFX_BANK_PREFETCH_EN
    else if (pf_issue_p0) begin
      ram_en   = 1'b1;
      ram_addr = served_addr + ADDR_ONE;
    end
`endif
  end

  bank_ram #(
    .BITS      (BITS),
    .ADDR_BITS (BANK_ADDRESS_BITS)
  ) u_bank_ram (
    .CLK  (CLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign CPU_DOUT = cpu_rd_p1 ? ram_dout : cpu_dout_q;

  // Stage p1: RAM output is steered to the CPU hold register or into GFX_DOUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      GFX_READY  <= 1'b0;
      GFX_DOUT   <= '0;
      cpu_rd_p1  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      cpu_rd_p1  <= CPU_RD && !CPU_WR;
      cpu_dout_q <= CPU_DOUT;
      GFX_READY  <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef GFX_BANK_PREFETCH_EN
          if (pf_hit_p0) begin
            state     <= ST_RESP;
            GFX_DOUT  <= pf_vld ? pf_data : ram_dout;
            GFX_READY <= 1'b1;
          end else
`endif
          if (gfx_req_p0) state <= ST_READ;
        end
        ST_READ: begin
          state     <= ST_RESP;
          GFX_DOUT  <= ram_dout;
          GFX_READY <= 1'b1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GFX_BANK_PREFETCH_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pf_pend_p1 <= 1'b0;
      pf_vld     <= 1'b0;
    end else begin
      pf_pend_p1 <= pf_issue_p0;
      if ((state == ST_RESP) || pf_wr_hit_p0) pf_vld <= 1'b0;
      else if (pf_pend_p1)                    pf_vld <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (gfx_req_p0 || pf_hit_p0) served_addr <= GFX_ADDR;
    if (pf_issue_p0)             pf_tag      <= served_addr + ADDR_ONE;
    if (pf_pend_p1)              pf_data     <= ram_dout;
  end
`endif
endmodule

// File: doc/memory_bank_responder.md
MEMORY_BANK_RESPONDER -- requirements
Module: memory_bank_responder

Interface
REQ-001 Parameter BITS, default 16, data word width.
REQ-002 Parameter BANK_ADDRESS_BITS, default 14, word address width; bank depth 2**BANK_ADDRESS_BITS.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 CPU_ADDR  input  BANK_ADDRESS_BITS  CPU word address.
REQ-006 CPU_DIN  input  BITS  CPU write data.
REQ-007 CPU_WR  input  1  CPU write strobe, one access per high cycle.
REQ-008 CPU_RD  input  1  CPU read strobe, one access per high cycle.
REQ-009 CPU_DOUT  output  BITS  CPU read data.
REQ-010 GFX_ADDR  input  BANK_ADDRESS_BITS  graphics DMA read address.
REQ-011 GFX_VALID  input  1  graphics read request; ADDR held stable while high.
REQ-012 GFX_DOUT  output  BITS  graphics read data.
REQ-013 GFX_READY  output  1  one-cycle pulse; GFX_DOUT valid in the same cycle.

Function
REQ-014 The bank SHALL be a single-port synchronous RAM with 1-cycle read latency, accessed at most once per cycle.
REQ-015 A CPU access SHALL always win the RAM port in the cycle CPU_WR or CPU_RD is high; CPU_WR has precedence over CPU_RD if both are high.
REQ-016 CPU_DOUT SHALL present RAM data at the selected address one cycle after CPU_RD and hold it until the next CPU read.
REQ-017 The FSM SHALL have states IDLE, READ and RESP.
REQ-018 IDLE -> READ when GFX_VALID=1 and no CPU access; RAM read issued at GFX_ADDR; otherwise stay in IDLE.
REQ-019 READ -> RESP unconditionally; RAM data is registered into GFX_DOUT.
REQ-020 RESP: GFX_READY=1 for exactly one cycle, then -> IDLE; GFX_VALID sampled during RESP SHALL NOT start a new request.
REQ-021 Minimum latency SHALL be GFX_VALID rise to GFX_READY = 2 cycles; each CPU-access cycle in IDLE adds one cycle.
REQ-022 GFX_DOUT SHALL hold its last value when GFX_READY=0.
REQ-023 A CPU write to the address currently being read in READ SHALL NOT alter the returned data (port order: the graphics read was issued first).
REQ-024 Addresses SHALL be used unmodified; the prefetch address increments modulo 2**BANK_ADDRESS_BITS (wraps from max to 0).

Reset
REQ-025 While RST=1: state=IDLE, GFX_READY=0, GFX_DOUT=0, CPU_DOUT=0, prefetch valid flag=0; RAM contents unaffected.
REQ-026 Reset asserted mid-request SHALL abort it with no GFX_READY pulse; the requester re-issues after reset.

Configuration
REQ-027 Macro GFX_BANK_PREFETCH_EN SHALL enable a one-entry prefetch buffer; without it the design behaves exactly per REQ-017..REQ-024 with no prefetch logic.
REQ-028 With the macro, RESP SHALL issue a RAM read at (served address + 1) if no CPU access occurs that cycle, setting the prefetch valid flag and tag on the next cycle.
REQ-029 With the macro, IDLE with GFX_VALID=1 and a valid prefetch tag equal to GFX_ADDR SHALL go directly to RESP with the buffered data (latency 1 cycle), regardless of CPU activity.
REQ-030 With the macro, a CPU write to the prefetch tag address, or a CPU access in the prefetch cycle, SHALL clear the prefetch valid flag.

Structure
REQ-031 Shared package gfx_pkg SHALL hold the FSM state encoding and the default BITS/BANK_ADDRESS_BITS constants.
REQ-032 One sub-module, bank_ram (single-port synchronous RAM, write-first disabled, read-registered), SHALL hold the storage.

Verification
REQ-033 Reset, CPU write 0x1234 to 0x0010, GFX request 0x0010 -> GFX_READY 2 cycles after GFX_VALID, GFX_DOUT=0x1234.
REQ-034 GFX_VALID at 0x0020 with CPU_WR held high 3 cycles -> GFX_READY delayed to cycle 5; CPU writes all complete.
REQ-035 CPU_RD 0x0010 -> CPU_DOUT=0x1234 next cycle, held while CPU idle.
REQ-036 PREFETCH_EN: sequential GFX reads 0x3FFE, 0x3FFF, 0x0000 -> second and third READY 1 cycle after VALID; wrap correct.
REQ-037 PREFETCH_EN: prefetch 0x0101, CPU write 0xBEEF to 0x0101, GFX read 0x0101 -> 2-cycle latency, GFX_DOUT=0xBEEF.
REQ-038 RST pulse while state=READ -> no GFX_READY, outputs zero; re-issued request completes normally.
